sram_sync_1r1w: RTL and testbench

//  Simple-dual-port synchronous RAM: one write port, one read port, same clock.

---
 rtl/sram_sync_1r1w.sv | 110 +++++++++++
 tb/tb_sram_sync_1r1w.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sram_sync_1r1w.sv
// Simple-dual-port synchronous RAM: independent write and read ports on one clock,
// optional byte enables, read latency 1 or 2, and defined same-address collision behaviour.
module sram_sync_1r1w #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2048,
   parameter int BYTE_ENABLE  = 0,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_FIRST  = 1,
   parameter     PRELOAD_FILE = "NONE",
   parameter int ADDR_WIDTH   = $clog2(DEPTH),
   localparam int WEN_W       = (BYTE_ENABLE != 0) ? WIDTH / 8 : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WEN_W-1:0]      wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rvalid,
   output logic [WIDTH-1:0]      rdata
);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [WIDTH-1:0] wmask;
   logic             wr_ok;
   logic             rd_oob;

   assign wr_ok  = rst_n && ({1'b0, waddr} < DEPTH_L);
   assign rd_oob = !({1'b0, raddr} < DEPTH_L);

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
         $error("sram_sync_1r1w: READ_LATENCY must be 1 or 2");
      end
      if (BYTE_ENABLE != 0 && (WIDTH % 8) != 0) begin : g_bad_w
         $error("sram_sync_1r1w: WIDTH must be a multiple of 8 with BYTE_ENABLE");
      end

      if (BYTE_ENABLE != 0) begin : g_be
         for (genvar b = 0; b < WEN_W; b++) begin : g_lane
            assign wmask[b*8 +: 8] = {8{wen[b]}};
         end
         always_ff @(posedge clk) begin
            if (wr_ok) begin
               for (int b = 0; b < WEN_W; b++) begin
                  if (wen[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end
      end else begin : g_word
         assign wmask = {WIDTH{wen[0]}};
         always_ff @(posedge clk) begin
            if (wr_ok && wen[0]) mem[waddr] <= wdata;
         end
      end
   endgenerate

   // Stage 1: array output register plus the bypass lanes captured alongside it,
   // so the collision merge and out-of-range zeroing stay outside the array.
   logic [WIDTH-1:0] s1_mem, s1_wd, s1_byp, s1_data;
   logic             s1_oob, s1_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_mem <= '0;
         s1_wd  <= '0;
         s1_byp <= '0;
         s1_oob <= 1'b0;
      end else begin
         s1_vld <= ren;
         if (ren) begin
            s1_mem <= mem[raddr];
            s1_wd  <= wdata;
            s1_byp <= (WRITE_FIRST != 0 && raddr == waddr) ? wmask : '0;
            s1_oob <= rd_oob;
         end
      end
   end

   assign s1_data = s1_oob ? '0 : ((s1_mem & ~s1_byp) | (s1_wd & s1_byp));

   generate
      if (READ_LATENCY == 2) begin : g_rl2
         logic             s2_vld;
         logic [WIDTH-1:0] s2_data;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s2_vld  <= 1'b0;
               s2_data <= '0;
            end else begin
               s2_vld <= s1_vld;
               if (s1_vld) s2_data <= s1_data;
            end
         end
         assign rvalid = s2_vld;
         assign rdata  = s2_data;
      end else if (READ_LATENCY == 1) begin : g_rl1
         assign rvalid = s1_vld;
         assign rdata  = s1_data;
      end else begin : g_rl_none
         assign rvalid = 1'b0;
         assign rdata  = '0;
      end
   endgenerate

endmodule

// File: tb/tb_sram_sync_1r1w.sv
// Directed bench: byte-enable/collision table on two RL=1 instances (write-first and
// read-first), plus hand sequences on an RL=2, DEPTH=1000 instance.
module tb_sram_sync_1r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // A/B: BYTE_ENABLE=1, RL=1, WRITE_FIRST=1 / 0, shared stimulus
   logic        rst_n;
   logic [3:0]  wen;
   logic [10:0] waddr, raddr;
   logic [31:0] wdata;
   logic        ren;
   logic        rvalid_a, rvalid_b;
   logic [31:0] rdata_a, rdata_b;

   // C: BYTE_ENABLE=0, RL=2, DEPTH=1000
   logic        rst_c;
   logic [0:0]  wen_c;
   logic [9:0]  waddr_c, raddr_c;
   logic [31:0] wdata_c;
   logic        ren_c;
   logic        rvalid_c;
   logic [31:0] rdata_c;

   sram_sync_1r1w #(.BYTE_ENABLE(1), .WRITE_FIRST(1)) u_a (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rvalid(rvalid_a), .rdata(rdata_a));

   sram_sync_1r1w #(.BYTE_ENABLE(1), .WRITE_FIRST(0)) u_b (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rvalid(rvalid_b), .rdata(rdata_b));

   sram_sync_1r1w #(.DEPTH(1000), .READ_LATENCY(2)) u_c (
      .clk(clk), .rst_n(rst_c), .wen(wen_c), .waddr(waddr_c), .wdata(wdata_c),
      .ren(ren_c), .raddr(raddr_c), .rvalid(rvalid_c), .rdata(rdata_c));

   typedef struct {
      logic [3:0]  wen;
      logic [10:0] waddr;
      logic [31:0] wdata;
      logic        ren;
      logic [10:0] raddr;
      logic        exp_v;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_c(input string nm, input logic ev, input logic [31:0] ed);
      chk({nm, "_rvalid"}, {31'b0, rvalid_c}, {31'b0, ev});
      chk({nm, "_rdata"}, rdata_c, ed);
   endtask

   initial begin
      vec_t vecs[11];
      vecs[0]  = '{4'hF, 11'd5, 32'hDEADBEEF, 1'b0, 11'd0, 1'b0, 32'h00000000, 32'h00000000};
      vecs[1]  = '{4'h0, 11'd0, 32'h0,        1'b1, 11'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{4'h2, 11'd5, 32'h0000AA00, 1'b0, 11'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3]  = '{4'h0, 11'd0, 32'h0,        1'b1, 11'd5, 1'b1, 32'hDEADAAEF, 32'hDEADAAEF};
      vecs[4]  = '{4'hF, 11'd7, 32'h11223344, 1'b0, 11'd0, 1'b0, 32'hDEADAAEF, 32'hDEADAAEF};
      vecs[5]  = '{4'h1, 11'd7, 32'h000000FF, 1'b1, 11'd7, 1'b1, 32'h112233FF, 32'h11223344};
      vecs[6]  = '{4'h0, 11'd0, 32'h0,        1'b1, 11'd7, 1'b1, 32'h112233FF, 32'h112233FF};
      vecs[7]  = '{4'h0, 11'd0, 32'h0,        1'b0, 11'd7, 1'b0, 32'h112233FF, 32'h112233FF};
      vecs[8]  = '{4'hF, 11'd9, 32'hAABBCCDD, 1'b1, 11'd5, 1'b1, 32'hDEADAAEF, 32'hDEADAAEF};
      vecs[9]  = '{4'h6, 11'd9, 32'h00123400, 1'b1, 11'd9, 1'b1, 32'hAA1234DD, 32'hAABBCCDD};
      vecs[10] = '{4'h0, 11'd0, 32'h0,        1'b1, 11'd9, 1'b1, 32'hAA1234DD, 32'hAA1234DD};

      rst_n = 1'b0; wen = '0; waddr = '0; wdata = '0; ren = 1'b0; raddr = '0;
      rst_c = 1'b0; wen_c = '0; waddr_c = '0; wdata_c = '0; ren_c = 1'b0; raddr_c = '0;
      tick; tick;
      chk("rst_a_rvalid", {31'b0, rvalid_a}, 32'd0);
      chk("rst_a_rdata", rdata_a, 32'd0);
      chk("rst_b_rvalid", {31'b0, rvalid_b}, 32'd0);
      chk("rst_b_rdata", rdata_b, 32'd0);
      chk_c("rst_c", 1'b0, 32'd0);
      rst_n = 1'b1;
      rst_c = 1'b1;

      for (int i = 0; i < 11; i++) begin
         wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         ren = vecs[i].ren; raddr = vecs[i].raddr;
         tick;
         chk($sformatf("vec%0d_a_rvalid", i), {31'b0, rvalid_a}, {31'b0, vecs[i].exp_v});
         chk($sformatf("vec%0d_a_rdata", i), rdata_a, vecs[i].exp_a);
         chk($sformatf("vec%0d_b_rvalid", i), {31'b0, rvalid_b}, {31'b0, vecs[i].exp_v});
         chk($sformatf("vec%0d_b_rdata", i), rdata_b, vecs[i].exp_b);
      end
      wen = '0; ren = 1'b0;

      // C preload: mem[i] = 0x100+i, mem[999] = 0x777
      for (int i = 0; i < 5; i++) begin
         wen_c = 1'b1;
         waddr_c = (i == 4) ? 10'd999 : 10'(i);
         wdata_c = (i == 4) ? 32'h777 : 32'h100 + 32'(i);
         tick;
      end
      wen_c = 1'b0;

      // Streaming RL=2 reads; write to addr 0 at the edge after its read is sampled
      for (int k = 0; k < 7; k++) begin
         ren_c   = (k < 4);
         raddr_c = 10'(k);
         wen_c   = (k == 1);
         waddr_c = 10'd0;
         wdata_c = 32'h999;
         tick;
         chk_c($sformatf("stream%0d", k), (k >= 1 && k <= 4),
               (k == 0) ? 32'h0 : (k <= 4) ? 32'h100 + 32'(k - 1) : 32'h103);
      end
      wen_c = 1'b0; ren_c = 1'b0;

      // Reset arrives while a read is in flight, with a write that must be suppressed
      ren_c = 1'b1; raddr_c = 10'd3;
      tick; chk_c("flight_n", 1'b0, 32'h103);
      ren_c = 1'b0; rst_c = 1'b0; wen_c = 1'b1; waddr_c = 10'd3; wdata_c = 32'h0;
      tick; chk_c("flight_rst", 1'b0, 32'h0);
      rst_c = 1'b1; wen_c = 1'b0;
      tick; chk_c("flight_rel", 1'b0, 32'h0);
      ren_c = 1'b1; raddr_c = 10'd3;
      tick; chk_c("reread3_a", 1'b0, 32'h0);
      ren_c = 1'b0;
      tick; chk_c("reread3_b", 1'b1, 32'h103);

      // Out-of-range write and read at DEPTH=1000
      wen_c = 1'b1; waddr_c = 10'd1000; wdata_c = 32'h55;
      tick; chk_c("oob_wr", 1'b0, 32'h103);
      wen_c = 1'b0; ren_c = 1'b1; raddr_c = 10'd1000;
      tick; chk_c("oob_rd_a", 1'b0, 32'h103);
      raddr_c = 10'd999;
      tick; chk_c("oob_rd1000", 1'b1, 32'h0);
      ren_c = 1'b0;
      tick; chk_c("rd999", 1'b1, 32'h777);
      tick; chk_c("hold999", 1'b0, 32'h777);

      // Write at N+1 during the stream did land in the array
      ren_c = 1'b1; raddr_c = 10'd0;
      tick;
      ren_c = 1'b0;
      tick; chk_c("rd0_after_wr", 1'b1, 32'h999);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
